// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Sequencer states of the shift-and-add multiplier.
  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/shift_add_mult_rca.sv
// Ripple-carry adder: SIZE-bit a + b with no carry-in, carry-out in result[SIZE].
// Latency: combinational.
// Backpressure: none.
module RCA #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result
);

  logic [SIZE:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign result[i]  = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign result[SIZE] = carry[SIZE];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier, one shift-and-add partial product per clock.
// Latency: start sampled at edge t0, product and done at edge t0+WIDTH.
// Backpressure: start is taken only while busy is low; starts during RUN are dropped.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import alu_pkg::*;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mul_state_t            state;
  mul_state_t            state_nxt;
  logic [WIDTH-1:0]      mcand;
  logic [2*WIDTH:0]      acc;
  logic [CW-1:0]         count;

  logic [WIDTH-1:0]      addend;
  logic [WIDTH:0]        sum;
  logic [2*WIDTH:0]      acc_nxt;
  logic                  last_step;

  // The adder only ever sees the upper half of the accumulator and the
  // multiplicand gated by the current multiplier bit.
  RCA #(.SIZE(WIDTH)) u_rca (
    .a      (acc[2*WIDTH-1:WIDTH]),
    .b      (addend),
    .result (sum)
  );

  // Next state plus the shifted accumulator for this RUN cycle.
  always_comb begin
    state_nxt = state;
    addend    = acc[0] ? mcand : '0;
    last_step = (count == LAST);
    // Right shift by one keeping the adder carry. acc[2*WIDTH] is always zero
    // between steps, so carrying it along as the new MSB is a plain zero fill;
    // the concatenation-then-shift form also works for WIDTH == 1 where the
    // retained low slice is empty.
    acc_nxt   = (2*WIDTH+1)'({acc[2*WIDTH], sum, acc[WIDTH-1:0]} >> 1);
    unique case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (last_step) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // State register, operand capture, shift/accumulate and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MUL_IDLE;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        MUL_IDLE, MUL_DONE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{(WIDTH+1){1'b0}}, b};
            count <= '0;
          end
        end
        MUL_RUN: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (last_step) product <= acc_nxt[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // Both flags are straight decodes of the state register.
  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);

endmodule
